// File: rtl/synaptic_current_accumulator_pkg.sv
// Shared types and helpers for the synaptic current accumulator.
// Optional CURRENT_CARRY_EN behaviour lives in the top module.
package synaptic_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    sat;
  } clamp_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned ngroups(input int unsigned m, input int unsigned lanes);
    return (m + lanes - 1) / lanes;
  endfunction

  function automatic int unsigned acc_width(input int unsigned m, input int unsigned ww);
    return ww + clog2(m) + 1;
  endfunction

  localparam int unsigned NGROUPS = ngroups(16, 4);
  localparam int unsigned ACC_W   = acc_width(16, 4);

  // Clamp a wide signed value to the range of an out_w-bit signed number.
  function automatic clamp_t sat_clamp(input logic signed [SAT_W-1:0] acc,
                                       input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    clamp_t r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (acc < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end else begin
      r.value = acc;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/synaptic_current_accumulator_lane_adder_tree.sv
// Combinational partial sum of one group of synapses; masked or
// non-spiking lanes contribute zero.
module lane_adder_tree #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WW    = 4,
  parameter int unsigned ACC_W = 9
) (
  input  logic [LANES-1:0]          spikes_i,
  input  logic [LANES*WW-1:0]       weights_i,
  input  logic [LANES-1:0]          mask_i,
  output logic signed [ACC_W-1:0]   sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (spikes_i[j] && mask_i[j])
        sum_o = sum_o + ACC_W'($signed(weights_i[j*WW +: WW]));
    end
  end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// Multi-cycle saturating sum of spiking synapse weights, LANES per cycle.
// Define CURRENT_CARRY_EN to seed each sum with half the previous result.
module synaptic_current_accumulator
  import synaptic_pkg::*;
#(
  parameter int unsigned M     = 16,
  parameter int unsigned WW    = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [M-1:0]            input_spikes,
  input  logic [M*WW-1:0]         weights,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] input_current,
  output logic                    saturated
);

  localparam int unsigned NGRP = ngroups(M, LANES);
  localparam int unsigned AW   = acc_width(M, WW);
  localparam int unsigned GW   = (NGRP > 1) ? clog2(NGRP) : 1;
  localparam int unsigned PAD  = NGRP * LANES;

  state_t                  state_q, state_d;
  logic [M-1:0]            spk_q, spk_d;
  logic [M*WW-1:0]         w_q, w_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0] cur_q, cur_d;
  logic                    sat_q, sat_d;
  logic                    done_q, done_d;

  logic [PAD-1:0]          spk_pad;
  logic [PAD*WW-1:0]       w_pad;
  logic [LANES-1:0]        lane_spk;
  logic [LANES*WW-1:0]     lane_w;
  logic [LANES-1:0]        lane_mask;
  logic signed [AW-1:0]    lane_sum;
  logic signed [AW-1:0]    seed;
  clamp_t                  cl;
  logic                    unused_clamp_hi;

  // Snapshots are zero-padded to whole groups so the group select is a plain shift.
  assign spk_pad  = PAD'(spk_q);
  assign w_pad    = (PAD*WW)'(w_q);
  assign lane_spk = LANES'(spk_pad >> (grp_q * LANES));
  assign lane_w   = (LANES*WW)'(w_pad >> (grp_q * LANES * WW));

  always_comb begin
    lane_mask = '0;
    for (int unsigned j = 0; j < LANES; j++)
      lane_mask[j] = (32'(grp_q) * LANES + j) < M;
  end

  lane_adder_tree #(
    .LANES (LANES),
    .WW    (WW),
    .ACC_W (AW)
  ) u_tree (
    .spikes_i  (lane_spk),
    .weights_i (lane_w),
    .mask_i    (lane_mask),
    .sum_o     (lane_sum)
  );

  always_comb begin
`ifdef CURRENT_CARRY_EN
    seed = AW'(cur_q >>> 1);
`else
    seed = '0;
`endif
  end

  assign cl              = sat_clamp(SAT_W'(acc_q), OUT_W);
  assign unused_clamp_hi = ^cl.value[SAT_W-1:OUT_W];

  always_comb begin
    state_d = state_q;
    spk_d   = spk_q;
    w_d     = w_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    cur_d   = cur_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          spk_d   = input_spikes;
          w_d     = weights;
          acc_d   = seed;
          grp_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + lane_sum;
        if (grp_q == GW'(NGRP - 1))
          state_d = SAT;
        else
          grp_d = grp_q + 1'b1;
      end
      SAT: begin
        cur_d   = cl.value[OUT_W-1:0];
        sat_d   = cl.sat;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      spk_q   <= '0;
      w_q     <= '0;
      grp_q   <= '0;
      acc_q   <= '0;
      cur_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spk_q   <= spk_d;
      w_q     <= w_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      cur_q   <= cur_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign input_current = cur_q;
  assign saturated     = sat_q;

endmodule
